// File: rtl/cellrv32_bus_arbiter_pkg.sv
// Shared definitions for the two-port internal bus arbiter: FSM state codes,
// bus source encoding and the timer sizing helper.
package cellrv32_bus_arbiter_pkg;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t S_IDLE   = 3'd0;
    localparam arb_state_t S_A_REQ  = 3'd1;
    localparam arb_state_t S_A_WAIT = 3'd2;
    localparam arb_state_t S_B_REQ  = 3'd3;
    localparam arb_state_t S_B_WAIT = 3'd4;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam logic [3:0] BEN_ALL = 4'b1111;

    // Bits needed to index n entries (ceil(log2(n))), 0 for n <= 1.
    function automatic int index_size_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cellrv32_bus_arbiter.sv
// Shares one internal bus between the CPU data port (A) and the i-cache refill
// port (B): buffered request strobes, fixed priority A > B, optional refill lock.
module cellrv32_bus_arbiter
    import cellrv32_bus_arbiter_pkg::*;
#(
    parameter bit B_LOCK_EN = 1'b1,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    // port A: CPU data access
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    input  logic [3:0]  a_ben_i,
    input  logic        a_re_i,
    input  logic        a_we_i,
    output logic [31:0] a_rdata_o,
    output logic        a_ack_o,
    output logic        a_err_o,
    // port B: i-cache refill, read-only
    input  logic        b_cached_i,
    input  logic [31:0] b_addr_i,
    input  logic        b_re_i,
    output logic [31:0] b_rdata_o,
    output logic        b_ack_o,
    output logic        b_err_o,
    // shared bus
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_ben_o,
    output logic        bus_re_o,
    output logic        bus_we_o,
    output logic        bus_src_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    output logic        bus_timeout_o
);

    localparam int TW = index_size_f(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT > 0);

    arb_state_t    state_q, state_d;
    logic          a_pend_q, a_pend_d;
    logic          a_wr_q, a_wr_d;
    logic          b_pend_q, b_pend_d;
    logic          cur_wr_q, cur_wr_d;
    logic          src_q, src_d;
    logic [TW-1:0] timer_q, timer_d;

    logic a_stb, a_req, b_req, b_lock, in_wait;
    logic rsp_ack, rsp_err, rsp_to;

    always_comb begin
        a_stb   = a_re_i | a_we_i;
        a_req   = a_pend_q | a_stb;
        b_req   = b_pend_q | b_re_i;
        b_lock  = B_LOCK_EN & b_cached_i;
        in_wait = (state_q == S_A_WAIT) || (state_q == S_B_WAIT);
        // ack beats err, and either beats the timeout in the same cycle
        rsp_ack = in_wait & bus_ack_i;
        rsp_err = in_wait & ~bus_ack_i & bus_err_i;
        rsp_to  = in_wait & ~bus_ack_i & ~bus_err_i & TO_EN & (timer_q == T_LAST);
    end

    always_comb begin
        state_d  = state_q;
        a_pend_d = a_pend_q | a_stb;
        a_wr_d   = a_stb ? a_we_i : a_wr_q;
        b_pend_d = b_pend_q | b_re_i;
        cur_wr_d = cur_wr_q;
        src_d    = src_q;
        timer_d  = timer_q;
        case (state_q)
            S_IDLE: begin
                if (a_req && !b_lock) begin
                    state_d  = S_A_REQ;
                    src_d    = SRC_A;
                    cur_wr_d = a_pend_q ? a_wr_q : a_we_i;
                    // a strobe arriving while an older one is served stays pending
                    a_pend_d = a_pend_q & a_stb;
                end else if (b_req) begin
                    state_d  = S_B_REQ;
                    src_d    = SRC_B;
                    cur_wr_d = 1'b0;
                    b_pend_d = b_pend_q & b_re_i;
                end
            end
            S_A_REQ: begin
                state_d = S_A_WAIT;
                timer_d = '0;
            end
            S_B_REQ: begin
                state_d = S_B_WAIT;
                timer_d = '0;
            end
            S_A_WAIT, S_B_WAIT: begin
                if (rsp_ack || rsp_err || rsp_to) begin
                    state_d = S_IDLE;
                end else if (TO_EN) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            a_pend_q <= 1'b0;
            a_wr_q   <= 1'b0;
            b_pend_q <= 1'b0;
            cur_wr_q <= 1'b0;
            src_q    <= SRC_A;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_pend_q <= a_pend_d;
            a_wr_q   <= a_wr_d;
            b_pend_q <= b_pend_d;
            cur_wr_q <= cur_wr_d;
            src_q    <= src_d;
            timer_q  <= timer_d;
        end
    end

    // Strobes and responses are masked while reset is asserted so an in-flight
    // response arriving in the reset cycle never reaches a master.
    always_comb begin
        bus_src_o     = src_q;
        bus_addr_o    = (src_q == SRC_B) ? b_addr_i : a_addr_i;
        bus_wdata_o   = (src_q == SRC_B) ? 32'h0 : a_wdata_i;
        bus_ben_o     = (src_q == SRC_B) ? BEN_ALL : a_ben_i;
        bus_re_o      = rstn_i & (((state_q == S_A_REQ) & ~cur_wr_q) | (state_q == S_B_REQ));
        bus_we_o      = rstn_i & (state_q == S_A_REQ) & cur_wr_q;
        a_ack_o       = rstn_i & (state_q == S_A_WAIT) & rsp_ack;
        a_err_o       = rstn_i & (state_q == S_A_WAIT) & (rsp_err | rsp_to);
        b_ack_o       = rstn_i & (state_q == S_B_WAIT) & rsp_ack;
        b_err_o       = rstn_i & (state_q == S_B_WAIT) & (rsp_err | rsp_to);
        a_rdata_o     = a_ack_o ? bus_rdata_i : 32'h0;
        b_rdata_o     = b_ack_o ? bus_rdata_i : 32'h0;
        bus_timeout_o = rstn_i & rsp_to;
    end

endmodule

// File: tb/tb_cellrv32_bus_arbiter.sv
// Bench for cellrv32_bus_arbiter: a locking instance and a non-locking one run
// side by side against a cycle-level owner/phase reference model.
module tb_cellrv32_bus_arbiter;

    localparam int ND = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [31:0] a_addr [ND], a_wdata [ND], b_addr [ND], bus_rdata [ND];
    logic [3:0]  a_ben [ND];
    logic        a_re [ND], a_we [ND], b_cached [ND], b_re [ND], bus_ack [ND], bus_err [ND];
    logic [31:0] a_rdata [ND], b_rdata [ND], bus_addr [ND], bus_wdata [ND];
    logic [3:0]  bus_ben [ND];
    logic        a_ack [ND], a_err [ND], b_ack [ND], b_err [ND];
    logic        bus_re [ND], bus_we [ND], bus_src [ND], bus_to [ND];

    cellrv32_bus_arbiter #(.B_LOCK_EN(1'b1), .TIMEOUT(15)) u_lock (
        .clk_i(clk), .rstn_i(rstn),
        .a_addr_i(a_addr[0]), .a_wdata_i(a_wdata[0]), .a_ben_i(a_ben[0]),
        .a_re_i(a_re[0]), .a_we_i(a_we[0]), .a_rdata_o(a_rdata[0]),
        .a_ack_o(a_ack[0]), .a_err_o(a_err[0]),
        .b_cached_i(b_cached[0]), .b_addr_i(b_addr[0]), .b_re_i(b_re[0]),
        .b_rdata_o(b_rdata[0]), .b_ack_o(b_ack[0]), .b_err_o(b_err[0]),
        .bus_addr_o(bus_addr[0]), .bus_wdata_o(bus_wdata[0]), .bus_ben_o(bus_ben[0]),
        .bus_re_o(bus_re[0]), .bus_we_o(bus_we[0]), .bus_src_o(bus_src[0]),
        .bus_rdata_i(bus_rdata[0]), .bus_ack_i(bus_ack[0]), .bus_err_i(bus_err[0]),
        .bus_timeout_o(bus_to[0])
    );

    cellrv32_bus_arbiter #(.B_LOCK_EN(1'b0), .TIMEOUT(6)) u_nolock (
        .clk_i(clk), .rstn_i(rstn),
        .a_addr_i(a_addr[1]), .a_wdata_i(a_wdata[1]), .a_ben_i(a_ben[1]),
        .a_re_i(a_re[1]), .a_we_i(a_we[1]), .a_rdata_o(a_rdata[1]),
        .a_ack_o(a_ack[1]), .a_err_o(a_err[1]),
        .b_cached_i(b_cached[1]), .b_addr_i(b_addr[1]), .b_re_i(b_re[1]),
        .b_rdata_o(b_rdata[1]), .b_ack_o(b_ack[1]), .b_err_o(b_err[1]),
        .bus_addr_o(bus_addr[1]), .bus_wdata_o(bus_wdata[1]), .bus_ben_o(bus_ben[1]),
        .bus_re_o(bus_re[1]), .bus_we_o(bus_we[1]), .bus_src_o(bus_src[1]),
        .bus_rdata_i(bus_rdata[1]), .bus_ack_i(bus_ack[1]), .bus_err_i(bus_err[1]),
        .bus_timeout_o(bus_to[1])
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model: who owns the bus and how many cycles since its strobe
    int m_own [ND];
    int m_ph [ND];
    bit m_ap [ND], m_awr [ND], m_bp [ND], m_owr [ND], m_src [ND];
    logic [139:0] exp_v [ND];

    // bus slave: s_cnt counts cycles since the last strobe it saw
    int s_cnt [ND], s_lat [ND], s_kind [ND];
    int cfg_lat, cfg_kind;
    bit cfg_rand, cfg_beef;
    bit f_ack [ND], f_err [ND];

    function automatic int to_of(int d);
        return (d == 0) ? 15 : 6;
    endfunction

    function automatic bit lock_of(int d);
        return d == 0;
    endfunction

    function automatic bit m_strobe(int d);
        return (rstn === 1'b1) && m_own[d] >= 0 && m_ph[d] == 0;
    endfunction

    function automatic logic [139:0] model_out(int d);
        bit stb, wt, ack, err, to, oa, ob;
        stb = m_strobe(d);
        wt  = (rstn === 1'b1) && m_own[d] >= 0 && m_ph[d] >= 1;
        ack = wt && bus_ack[d];
        err = wt && !bus_ack[d] && bus_err[d];
        to  = wt && !bus_ack[d] && !bus_err[d] && m_ph[d] == to_of(d);
        oa  = m_own[d] == 0;
        ob  = m_own[d] == 1;
        return {stb && !m_owr[d], stb && m_owr[d], m_src[d],
                m_src[d] ? b_addr[d] : a_addr[d], m_src[d] ? 4'hF : a_ben[d],
                m_src[d] ? 32'h0 : a_wdata[d],
                ack && oa, (err || to) && oa, (ack && oa) ? bus_rdata[d] : 32'h0,
                ack && ob, (err || to) && ob, (ack && ob) ? bus_rdata[d] : 32'h0,
                to};
    endfunction

    function automatic logic [139:0] dut_out(int d);
        return {bus_re[d], bus_we[d], bus_src[d], bus_addr[d], bus_ben[d],
                m_src[d] ? 32'h0 : bus_wdata[d],
                a_ack[d], a_err[d], a_rdata[d], b_ack[d], b_err[d], b_rdata[d], bus_to[d]};
    endfunction

    task automatic quiet();
        for (int d = 0; d < ND; d++) begin
            a_re[d] = 1'b0;
            a_we[d] = 1'b0;
            b_re[d] = 1'b0;
        end
    endtask

    // drive the slave's response for this cycle, let logic settle, compute expectations
    task automatic settle();
        for (int d = 0; d < ND; d++) begin
            bit hit;
            hit = s_cnt[d] > 0 && s_cnt[d] == s_lat[d];
            bus_ack[d]   = f_ack[d] || (hit && (s_kind[d] == 0 || s_kind[d] == 3));
            bus_err[d]   = f_err[d] || (hit && (s_kind[d] == 1 || s_kind[d] == 3));
            bus_rdata[d] = cfg_beef ? 32'hDEAD_BEEF : $urandom;
        end
        #1;
        for (int d = 0; d < ND; d++) exp_v[d] = model_out(d);
    endtask

    task automatic tick();
        bit stb [ND];
        for (int d = 0; d < ND; d++) stb[d] = m_strobe(d);
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            bit a_new, done;
            a_new = a_re[d] || a_we[d];
            done  = bus_ack[d] || bus_err[d] || m_ph[d] == to_of(d);
            if (rstn !== 1'b1) begin
                m_own[d] = -1; m_ph[d] = 0; m_ap[d] = 0; m_awr[d] = 0;
                m_bp[d] = 0; m_owr[d] = 0; m_src[d] = 0;
            end else if (m_own[d] < 0) begin
                if ((m_ap[d] || a_new) && !(lock_of(d) && b_cached[d])) begin
                    m_owr[d] = m_ap[d] ? m_awr[d] : a_we[d];
                    m_ap[d]  = m_ap[d] && a_new;
                    m_bp[d]  = m_bp[d] || b_re[d];
                    m_own[d] = 0; m_src[d] = 0; m_ph[d] = 0;
                end else if (m_bp[d] || b_re[d]) begin
                    m_bp[d]  = m_bp[d] && b_re[d];
                    m_ap[d]  = m_ap[d] || a_new;
                    m_owr[d] = 0; m_own[d] = 1; m_src[d] = 1; m_ph[d] = 0;
                end else begin
                    m_ap[d] = m_ap[d] || a_new;
                    m_bp[d] = m_bp[d] || b_re[d];
                end
                if (a_new) m_awr[d] = a_we[d];
            end else begin
                m_ap[d] = m_ap[d] || a_new;
                m_bp[d] = m_bp[d] || b_re[d];
                if (a_new) m_awr[d] = a_we[d];
                if (m_ph[d] == 0) m_ph[d] = 1;
                else if (done) m_own[d] = -1;
                else m_ph[d]++;
            end
            if (stb[d]) begin
                s_cnt[d] = 1;
                if (cfg_rand) begin
                    int r;
                    r = $urandom_range(19);
                    s_lat[d]  = $urandom_range(4, 1);
                    s_kind[d] = (r < 14) ? 0 : (r < 17) ? 1 : (r < 19) ? 3 : 2;
                end else begin
                    s_lat[d]  = cfg_lat;
                    s_kind[d] = cfg_kind;
                end
            end else if (s_cnt[d] > 0) begin
                if (s_cnt[d] == s_lat[d] && s_kind[d] != 2) s_cnt[d] = 0;
                else s_cnt[d]++;
            end
            f_ack[d] = 1'b0;
            f_err[d] = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        quiet();
        settle();
        tick();
        settle();
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (dut_out(d) !== exp_v[d]) begin
                miscompares++;
                $display("FAIL reset dut%0d got %h want %h", d, dut_out(d), exp_v[d]);
            end
            vectors++;
            if ({bus_src[d], bus_re[d], bus_we[d], a_ack[d], a_err[d], b_ack[d], b_err[d], bus_to[d]} !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_outs dut%0d got %b want 00000000", d,
                         {bus_src[d], bus_re[d], bus_we[d], a_ack[d], a_err[d], b_ack[d], b_err[d], bus_to[d]});
            end
        end
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_single_read();
        int t_re [ND], t_ack [ND];
        logic [31:0] rd [ND], adr [ND];
        bit b_any [ND];
        cfg_rand = 0; cfg_lat = 2; cfg_kind = 0; cfg_beef = 1;
        for (int d = 0; d < ND; d++) begin
            t_re[d] = -1; t_ack[d] = -1; rd[d] = 0; adr[d] = 0; b_any[d] = 0;
            a_addr[d] = 32'h0000_1000; a_ben[d] = 4'hF; a_wdata[d] = 32'h0; b_cached[d] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            quiet();
            for (int d = 0; d < ND; d++) a_re[d] = (c == 0);
            settle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if (dut_out(d) !== exp_v[d]) begin
                    miscompares++;
                    $display("FAIL single_read dut%0d c=%0d got %h want %h", d, c, dut_out(d), exp_v[d]);
                end
                if (bus_re[d] && t_re[d] < 0) begin t_re[d] = c; adr[d] = bus_addr[d]; end
                if (a_ack[d] && t_ack[d] < 0) begin t_ack[d] = c; rd[d] = a_rdata[d]; end
                if (b_ack[d] || b_err[d] || b_rdata[d] != 0) b_any[d] = 1;
            end
            tick();
        end
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (t_re[d] != 1 || adr[d] !== 32'h0000_1000) begin
                miscompares++;
                $display("FAIL single_read_strobe dut%0d cycle %0d addr %h want cycle 1 addr 00001000", d, t_re[d], adr[d]);
            end
            vectors++;
            if (t_ack[d] != 3 || rd[d] !== 32'hDEAD_BEEF) begin
                miscompares++;
                $display("FAIL single_read_ack dut%0d cycle %0d data %h want cycle 3 data deadbeef", d, t_ack[d], rd[d]);
            end
            vectors++;
            if (b_any[d]) begin
                miscompares++;
                $display("FAIL single_read_b_quiet dut%0d got activity want none", d);
            end
        end
        cfg_beef = 0;
    endtask

    task automatic test_same_cycle();
        int t_we [ND], t_aack [ND], t_bre [ND], n_aack [ND], n_back [ND];
        bit we_src [ND];
        cfg_rand = 0; cfg_lat = 1; cfg_kind = 0;
        for (int d = 0; d < ND; d++) begin
            t_we[d] = -1; t_aack[d] = -1; t_bre[d] = -1; n_aack[d] = 0; n_back[d] = 0; we_src[d] = 1;
            a_addr[d] = 32'h0000_0040; a_wdata[d] = $urandom; a_ben[d] = 4'b0011; b_addr[d] = 32'h0000_2000;
        end
        for (int c = 0; c < 10; c++) begin
            quiet();
            for (int d = 0; d < ND; d++) begin
                a_we[d] = (c == 0);
                b_re[d] = (c == 0);
            end
            settle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if (dut_out(d) !== exp_v[d]) begin
                    miscompares++;
                    $display("FAIL same_cycle dut%0d c=%0d got %h want %h", d, c, dut_out(d), exp_v[d]);
                end
                if (bus_we[d] && t_we[d] < 0) begin t_we[d] = c; we_src[d] = bus_src[d]; end
                if (bus_re[d] && t_bre[d] < 0) t_bre[d] = c;
                if (a_ack[d]) begin n_aack[d]++; if (t_aack[d] < 0) t_aack[d] = c; end
                if (b_ack[d]) n_back[d]++;
            end
            tick();
        end
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (t_we[d] != 1 || we_src[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL same_cycle_a_first dut%0d we cycle %0d src %b want 1 src 0", d, t_we[d], we_src[d]);
            end
            vectors++;
            if (t_aack[d] != 2 || t_bre[d] != 4) begin
                miscompares++;
                $display("FAIL same_cycle_order dut%0d a_ack %0d b_strobe %0d want 2 and 4", d, t_aack[d], t_bre[d]);
            end
            vectors++;
            if (n_aack[d] != 1 || n_back[d] != 1) begin
                miscompares++;
                $display("FAIL same_cycle_once dut%0d a_acks %0d b_acks %0d want 1 and 1", d, n_aack[d], n_back[d]);
            end
        end
    endtask

    task automatic test_refill();
        int words [ND], nstb [ND], n_aack [ND];
        logic [7:0] seq [ND];
        bit nxt_re [ND], nxt_unc [ND];
        cfg_rand = 0; cfg_lat = 1; cfg_kind = 0;
        for (int d = 0; d < ND; d++) begin
            words[d] = 1; nstb[d] = 0; n_aack[d] = 0; seq[d] = 8'h0;
            nxt_re[d] = 0; nxt_unc[d] = 0;
            b_cached[d] = 1; b_addr[d] = 32'h0000_3000; a_addr[d] = 32'h0000_0100; a_ben[d] = 4'hF;
        end
        for (int c = 0; c < 30; c++) begin
            quiet();
            for (int d = 0; d < ND; d++) begin
                b_re[d] = (c == 0) || nxt_re[d];
                if (nxt_re[d]) b_addr[d] = b_addr[d] + 32'd4;
                if (nxt_unc[d]) b_cached[d] = 0;
                a_re[d] = (c == 2);
                nxt_re[d] = 0; nxt_unc[d] = 0;
            end
            settle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if (dut_out(d) !== exp_v[d]) begin
                    miscompares++;
                    $display("FAIL refill dut%0d c=%0d got %h want %h", d, c, dut_out(d), exp_v[d]);
                end
                if (bus_re[d] || bus_we[d]) begin
                    seq[d] = {seq[d][6:0], bus_src[d]};
                    nstb[d]++;
                end
                if (a_ack[d]) n_aack[d]++;
                if (b_ack[d]) begin
                    if (words[d] < 4) begin nxt_re[d] = 1; words[d]++; end
                    else nxt_unc[d] = 1;
                end
            end
            tick();
        end
        vectors++;
        if (nstb[0] != 5 || seq[0] !== 8'b0001_1110 || n_aack[0] != 1) begin
            miscompares++;
            $display("FAIL refill_locked strobes %0d order %b a_acks %0d want 5 00011110 1", nstb[0], seq[0], n_aack[0]);
        end
        vectors++;
        if (nstb[1] != 5 || seq[1] !== 8'b0001_0111 || n_aack[1] != 1) begin
            miscompares++;
            $display("FAIL refill_interleave strobes %0d order %b a_acks %0d want 5 00010111 1", nstb[1], seq[1], n_aack[1]);
        end
        for (int d = 0; d < ND; d++) b_cached[d] = 0;
    endtask

    task automatic test_timeout();
        int t_stb [ND], t_err [ND], t_to [ND], n_back [ND];
        cfg_rand = 0; cfg_lat = 1; cfg_kind = 2;
        for (int d = 0; d < ND; d++) begin
            t_stb[d] = -1; t_err[d] = -1; t_to[d] = -1; n_back[d] = 0;
            b_addr[d] = 32'h0000_4000;
        end
        for (int c = 0; c < 45; c++) begin
            quiet();
            for (int d = 0; d < ND; d++) begin
                b_re[d]  = (c == 0);
                f_err[d] = (c == 1);
                f_ack[d] = (c == 40);
            end
            settle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if (dut_out(d) !== exp_v[d]) begin
                    miscompares++;
                    $display("FAIL timeout dut%0d c=%0d got %h want %h", d, c, dut_out(d), exp_v[d]);
                end
                if (bus_re[d] && t_stb[d] < 0) t_stb[d] = c;
                if (b_err[d] && t_err[d] < 0) t_err[d] = c;
                if (bus_to[d] && t_to[d] < 0) t_to[d] = c;
                if (b_ack[d]) n_back[d]++;
            end
            tick();
        end
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (t_stb[d] != 1 || t_err[d] != 1 + to_of(d) || t_to[d] != 1 + to_of(d)) begin
                miscompares++;
                $display("FAIL timeout_cycle dut%0d strobe %0d err %0d to %0d want 1 %0d %0d",
                         d, t_stb[d], t_err[d], t_to[d], 1 + to_of(d), 1 + to_of(d));
            end
            vectors++;
            if (n_back[d] != 0) begin
                miscompares++;
                $display("FAIL timeout_late_ack dut%0d b_acks %0d want 0", d, n_back[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_rsp [ND], n_stb [ND];
        cfg_rand = 0; cfg_lat = 1; cfg_kind = 2;
        for (int d = 0; d < ND; d++) begin
            n_rsp[d] = 0; n_stb[d] = 0;
            a_addr[d] = 32'h0000_5000; b_addr[d] = 32'h0000_6000;
        end
        for (int c = 0; c < 15; c++) begin
            quiet();
            rstn = (c == 3) ? 1'b0 : 1'b1;
            for (int d = 0; d < ND; d++) begin
                a_re[d]  = (c == 0);
                b_re[d]  = (c == 2);
                f_ack[d] = (c == 3) || (c == 5);
            end
            settle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if (dut_out(d) !== exp_v[d]) begin
                    miscompares++;
                    $display("FAIL reset_mid dut%0d c=%0d got %h want %h", d, c, dut_out(d), exp_v[d]);
                end
                if (a_ack[d] || a_err[d] || b_ack[d] || b_err[d] || bus_to[d]) n_rsp[d]++;
                if (c >= 3 && (bus_re[d] || bus_we[d])) n_stb[d]++;
            end
            tick();
        end
        rstn = 1'b1;
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (n_rsp[d] != 0 || n_stb[d] != 0 || bus_src[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_quiet dut%0d responses %0d strobes %0d src %b want 0 0 0",
                         d, n_rsp[d], n_stb[d], bus_src[d]);
            end
        end
    endtask

    task automatic test_random();
        bit a_out [ND], b_out [ND];
        cfg_rand = 1; cfg_beef = 0;
        for (int d = 0; d < ND; d++) begin a_out[d] = 0; b_out[d] = 0; end
        for (int c = 0; c < 800; c++) begin
            quiet();
            for (int d = 0; d < ND; d++) begin
                if (!a_out[d] && $urandom_range(3) == 0) begin
                    int k;
                    k = $urandom_range(7);
                    a_addr[d]  = $urandom;
                    a_wdata[d] = $urandom;
                    a_ben[d]   = 4'($urandom);
                    a_re[d]    = (k != 1);
                    a_we[d]    = (k <= 2);
                    a_out[d]   = 1;
                end
                if (!b_out[d] && $urandom_range(2) == 0) begin
                    b_addr[d] = $urandom;
                    b_re[d]   = 1;
                    b_out[d]  = 1;
                end
                if ($urandom_range(15) == 0) b_cached[d] = !b_cached[d];
                f_ack[d] = ($urandom_range(31) == 0);
                f_err[d] = ($urandom_range(31) == 0);
            end
            settle();
            for (int d = 0; d < ND; d++) begin
                vectors++;
                if (dut_out(d) !== exp_v[d]) begin
                    miscompares++;
                    $display("FAIL random dut%0d c=%0d got %h want %h", d, c, dut_out(d), exp_v[d]);
                end
                if (a_ack[d] || a_err[d]) a_out[d] = 0;
                if (b_ack[d] || b_err[d]) b_out[d] = 0;
            end
            tick();
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            m_own[d] = -1; m_ph[d] = 0; m_ap[d] = 0; m_awr[d] = 0; m_bp[d] = 0; m_owr[d] = 0; m_src[d] = 0;
            s_cnt[d] = 0; s_lat[d] = 1; s_kind[d] = 0; f_ack[d] = 0; f_err[d] = 0;
            a_addr[d] = 0; a_wdata[d] = 0; a_ben[d] = 4'hF; b_addr[d] = 0; b_cached[d] = 0;
            bus_ack[d] = 0; bus_err[d] = 0; bus_rdata[d] = 0;
        end
        cfg_lat = 1; cfg_kind = 0; cfg_rand = 0; cfg_beef = 0;
        test_reset();
        test_single_read();
        test_same_cycle();
        test_refill();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
